// File: rtl/gemm_tile_sched.sv
// Sequencer for the GEMM multiply-accumulate tile: walks C row-major, issues
// K back-to-back A/B reads per element, then writes the dot product to C.
module gemm_tile_sched #(
   parameter int DATA_WIDTH    = 64,
   parameter int MATRIX_WIDTH  = 4,
   parameter int MATRIX_HEIGHT = 4,
   parameter int MATRIX_ADJUST = 4,
   parameter int AW_A = (MATRIX_HEIGHT * MATRIX_ADJUST > 1) ? $clog2(MATRIX_HEIGHT * MATRIX_ADJUST) : 1,
   parameter int AW_B = (MATRIX_ADJUST * MATRIX_WIDTH > 1) ? $clog2(MATRIX_ADJUST * MATRIX_WIDTH) : 1,
   parameter int AW_C = (MATRIX_HEIGHT * MATRIX_WIDTH > 1) ? $clog2(MATRIX_HEIGHT * MATRIX_WIDTH) : 1
) (
   input  logic                  iclk,
   input  logic                  irst_n,
   input  logic                  istart,
   output logic                  obusy,
   output logic                  odone,
   output logic                  orden,
   output logic [AW_A-1:0]       oa_addr,
   output logic [AW_B-1:0]       ob_addr,
   output logic [DATA_WIDTH-1:0] ocurr_sum,
   input  logic [DATA_WIDTH-1:0] imac_sum,
   output logic                  oc_valid,
   output logic [AW_C-1:0]       oc_addr,
   output logic [DATA_WIDTH-1:0] oc_data,
   input  logic                  ic_ready
);

   localparam int IW = (MATRIX_HEIGHT > 1) ? $clog2(MATRIX_HEIGHT) : 1;
   localparam int JW = (MATRIX_WIDTH  > 1) ? $clog2(MATRIX_WIDTH)  : 1;
   localparam int KW = (MATRIX_ADJUST > 1) ? $clog2(MATRIX_ADJUST) : 1;
   localparam logic [IW-1:0] I_LAST = IW'(MATRIX_HEIGHT - 1);
   localparam logic [JW-1:0] J_LAST = JW'(MATRIX_WIDTH - 1);
   localparam logic [KW-1:0] K_LAST = KW'(MATRIX_ADJUST - 1);

   typedef enum logic [2:0] {IDLE, ISSUE, DRAIN1, DRAIN2, WRITE, DONE} state_t;

   state_t        state;
   state_t        state_next;
   logic [IW-1:0] i_cnt;
   logic [JW-1:0] j_cnt;
   logic [KW-1:0] k_cnt;
   logic          first;
   logic          last_i;
   logic          last_j;
   logic          last_k;

   assign last_i = (i_cnt == I_LAST);
   assign last_j = (j_cnt == J_LAST);
   assign last_k = (k_cnt == K_LAST);

   always_ff @(posedge iclk) begin
      if (!irst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (istart) state_next = ISSUE;
         ISSUE:   if (last_k) state_next = DRAIN1;
         DRAIN1:  state_next = DRAIN2;
         DRAIN2:  state_next = WRITE;
         WRITE:   if (ic_ready) state_next = (last_i && last_j) ? DONE : ISSUE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Element counters and the C write holding registers. `first` marks the
   // cycle in which product k=0 sits on the tile inputs, so the MAC starts from 0.
   always_ff @(posedge iclk) begin
      if (!irst_n) begin
         i_cnt   <= '0;
         j_cnt   <= '0;
         k_cnt   <= '0;
         first   <= 1'b0;
         oc_addr <= '0;
         oc_data <= '0;
      end else begin
         first <= (state == ISSUE) && (k_cnt == '0);
         case (state)
            IDLE: begin
               if (istart) begin
                  i_cnt <= '0;
                  j_cnt <= '0;
                  k_cnt <= '0;
               end
            end
            ISSUE: begin
               if (!last_k) k_cnt <= k_cnt + 1'b1;
            end
            DRAIN2: begin
               oc_data <= imac_sum;
               oc_addr <= AW_C'(int'(i_cnt) * MATRIX_WIDTH + int'(j_cnt));
            end
            WRITE: begin
               if (ic_ready) begin
                  k_cnt <= '0;
                  if (!last_j) begin
                     j_cnt <= j_cnt + 1'b1;
                  end else begin
                     j_cnt <= '0;
                     if (!last_i) i_cnt <= i_cnt + 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Running sum is forced to zero in IDLE as well, so a stale MAC value never leaks out.
   always_comb begin
      orden     = 1'b0;
      oa_addr   = '0;
      ob_addr   = '0;
      oc_valid  = 1'b0;
      odone     = 1'b0;
      obusy     = (state != IDLE) && (state != DONE);
      ocurr_sum = (first || state == IDLE) ? '0 : imac_sum;
      case (state)
         ISSUE: begin
            orden   = 1'b1;
            oa_addr = AW_A'(int'(i_cnt) * MATRIX_ADJUST + int'(k_cnt));
            ob_addr = AW_B'(int'(k_cnt) * MATRIX_WIDTH + int'(j_cnt));
         end
         WRITE:   oc_valid = 1'b1;
         DONE:    odone = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_gemm_tile_sched.sv
// Bench for gemm_tile_sched: a table of whole GEMM runs plus randomized runs,
// with a behavioural MAC/tile-buffer environment and a matrix-product reference.
module tb_gemm_tile_sched;

   localparam int H  = 4;
   localparam int N  = 4;
   localparam int K  = 4;
   localparam int DW = 64;
   localparam logic [63:0] STALE = 64'hDEAD_BEEF_0BAD_F00D;

   logic          iclk = 1'b0;
   logic          irst_n;
   logic          istart;
   logic          obusy;
   logic          odone;
   logic          orden;
   logic [3:0]    oa_addr;
   logic [3:0]    ob_addr;
   logic [DW-1:0] ocurr_sum;
   logic [DW-1:0] imac_sum;
   logic          oc_valid;
   logic [3:0]    oc_addr;
   logic [DW-1:0] oc_data;
   logic          ic_ready;

   always #5 iclk = ~iclk;

   gemm_tile_sched #(
      .DATA_WIDTH(DW), .MATRIX_WIDTH(N), .MATRIX_HEIGHT(H), .MATRIX_ADJUST(K)
   ) dut (
      .iclk(iclk), .irst_n(irst_n), .istart(istart), .obusy(obusy), .odone(odone),
      .orden(orden), .oa_addr(oa_addr), .ob_addr(ob_addr), .ocurr_sum(ocurr_sum),
      .imac_sum(imac_sum), .oc_valid(oc_valid), .oc_addr(oc_addr), .oc_data(oc_data),
      .ic_ready(ic_ready)
   );

   // Tile buffers (flattened row-major) and a registered MAC that only updates
   // when a product is actually present on its inputs.
   logic [63:0] a_mem [H*K];
   logic [63:0] b_mem [K*N];
   logic [63:0] tile_a;
   logic [63:0] tile_b;
   logic        tile_v;
   logic [63:0] mac_sum;

   always @(posedge iclk) begin
      if (!irst_n) begin
         tile_v  <= 1'b0;
         tile_a  <= '0;
         tile_b  <= '0;
         mac_sum <= STALE;
      end else begin
         tile_v <= orden;
         tile_a <= a_mem[oa_addr];
         tile_b <= b_mem[ob_addr];
         if (tile_v) mac_sum <= ocurr_sum + tile_a * tile_b;
      end
   end
   assign imac_sum = mac_sum;

   typedef struct {
      string       name;
      int          a_mode;
      int          b_mode;
      logic [63:0] a_fill;
      logic [63:0] b_fill;
      int          stall_addr;
      int          stall_len;
      bit          pulse_mid;
      bit          pulse_done;
      int          probe_addr;
      logic [63:0] probe_exp;
      int          exp_done;
      int          exp_zero;
   } vec_t;

   vec_t        vecs [6];
   logic [63:0] c_exp [H*N];
   logic [63:0] c_got [H*N];
   int          wait_tab [H*N];
   int          hs_exp [H*N];
   int          done_model;
   int          n_checks;
   int          n_fail;

   task automatic checkOutput(input string what, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", what, got, exp);
      end
   endtask

   // a_mode: 0 identity, 1 fill, 2 row 0 = fill and others 1, else random.
   // b_mode: 0 ramp r*N+c, 1 fill, else random.
   task automatic loadMatrices(input int a_mode, input int b_mode,
                               input logic [63:0] a_fill, input logic [63:0] b_fill);
      for (int r = 0; r < H; r++)
         for (int c = 0; c < K; c++)
            case (a_mode)
               0:       a_mem[r*K+c] = (r == c) ? 64'd1 : 64'd0;
               1:       a_mem[r*K+c] = a_fill;
               2:       a_mem[r*K+c] = (r == 0) ? a_fill : 64'd1;
               default: a_mem[r*K+c] = {$urandom, $urandom};
            endcase
      for (int r = 0; r < K; r++)
         for (int c = 0; c < N; c++)
            case (b_mode)
               0:       b_mem[r*N+c] = 64'(r*N + c);
               1:       b_mem[r*N+c] = b_fill;
               default: b_mem[r*N+c] = {$urandom, $urandom};
            endcase
   endtask

   // Reference: C = A*B modulo 2^64, plus the handshake timeline implied by
   // K+3 cycles per element and the chosen ready-delay per element.
   task automatic computeExpected();
      int t;
      logic [63:0] acc;
      for (int i = 0; i < H; i++)
         for (int j = 0; j < N; j++) begin
            acc = '0;
            for (int k = 0; k < K; k++) acc = acc + a_mem[i*K+k] * b_mem[k*N+j];
            c_exp[i*N+j] = acc;
         end
      t = 0;
      for (int e = 0; e < H*N; e++) begin
         hs_exp[e] = t + K + 2 + wait_tab[e];
         t = t + K + 3 + wait_tab[e];
      end
      done_model = t;
   endtask

   task automatic applyStimulus(input string tag, input bit pulse_mid, input bit pulse_done,
                                output int done_rel, output int zero_cnt);
      int rel = 0, nwr = 0, waited = 0, issue_k = 0;
      int hold_err = 0, orden_err = 0, busy_err = 0, addr_err = 0, done_cnt = 0, post_err = 0;
      bit in_write = 1'b0, finished = 1'b0;
      logic [3:0]  hold_addr = '0;
      logic [63:0] hold_data = '0;
      done_rel = -1;
      zero_cnt = 0;
      for (int n = 0; n < H*N; n++) c_got[n] = STALE;
      ic_ready = 1'b1;
      istart   = 1'b1;
      @(negedge iclk);
      istart = 1'b0;
      while (!finished && rel < 3000) begin
         if (obusy && ocurr_sum == '0) zero_cnt++;
         if (odone) begin
            done_cnt++;
            done_rel = rel;
            finished = 1'b1;
            if (obusy) busy_err++;
         end else if (!obusy) busy_err++;
         if (orden) begin
            if (nwr >= H*N || 64'(oa_addr) != 64'((nwr / N) * K + issue_k) ||
                64'(ob_addr) != 64'(issue_k * N + nwr % N)) addr_err++;
            issue_k++;
         end
         if (oc_valid) begin
            if (!in_write) begin
               in_write  = 1'b1;
               waited    = 0;
               hold_addr = oc_addr;
               hold_data = oc_data;
            end else if (oc_addr !== hold_addr || oc_data !== hold_data) hold_err++;
            if (orden) orden_err++;
            ic_ready = (nwr >= H*N) || (waited >= wait_tab[nwr]);
            if (!ic_ready) waited++;
            else begin
               in_write = 1'b0;
               if (issue_k != K) addr_err++;
               issue_k = 0;
               if (nwr < H*N) begin
                  checkOutput($sformatf("%s/c_addr[%0d]", tag, nwr), 64'(oc_addr), 64'(nwr));
                  checkOutput($sformatf("%s/c_data[%0d]", tag, nwr), oc_data, c_exp[nwr]);
                  checkOutput($sformatf("%s/hs_cycle[%0d]", tag, nwr), 64'(rel), 64'(hs_exp[nwr]));
                  c_got[oc_addr] = oc_data;
               end
               nwr++;
            end
         end else ic_ready = 1'($urandom_range(0, 1));
         istart = (pulse_mid && rel == 2) || (pulse_done && odone);
         @(negedge iclk);
         rel++;
      end
      istart   = 1'b0;
      ic_ready = 1'b1;
      checkOutput({tag, "/finished_in_budget"}, 64'(finished), 64'd1);
      repeat (3) begin
         if (obusy || odone || orden || oc_valid) post_err++;
         @(negedge iclk);
      end
      checkOutput({tag, "/write_count"}, 64'(nwr), 64'(H*N));
      checkOutput({tag, "/done_pulses"}, 64'(done_cnt), 64'd1);
      checkOutput({tag, "/hold_errors"}, 64'(hold_err), 64'd0);
      checkOutput({tag, "/orden_in_write"}, 64'(orden_err), 64'd0);
      checkOutput({tag, "/busy_errors"}, 64'(busy_err), 64'd0);
      checkOutput({tag, "/addr_errors"}, 64'(addr_err), 64'd0);
      checkOutput({tag, "/idle_after_done"}, 64'(post_err), 64'd0);
   endtask

   // Reset asserted during DRAIN2 of element 5 must drop everything.
   task automatic resetMidRun();
      int leak = 0;
      loadMatrices(0, 0, '0, '0);
      for (int n = 0; n < H*N; n++) wait_tab[n] = 0;
      computeExpected();
      ic_ready = 1'b1;
      istart   = 1'b1;
      @(negedge iclk);
      istart = 1'b0;
      repeat (5*(K+3) + K + 1) @(negedge iclk);
      checkOutput("rst/pre_oc_data", oc_data, c_exp[4]);
      irst_n = 1'b0;
      @(negedge iclk);
      irst_n = 1'b1;
      checkOutput("rst/obusy", 64'(obusy), 64'd0);
      checkOutput("rst/odone", 64'(odone), 64'd0);
      checkOutput("rst/orden", 64'(orden), 64'd0);
      checkOutput("rst/oc_valid", 64'(oc_valid), 64'd0);
      checkOutput("rst/oc_addr", 64'(oc_addr), 64'd0);
      checkOutput("rst/oc_data", oc_data, 64'd0);
      checkOutput("rst/ocurr_sum", ocurr_sum, 64'd0);
      checkOutput("rst/ab_addr", 64'({oa_addr, ob_addr}), 64'd0);
      repeat (10) begin
         if (oc_valid || odone || obusy) leak++;
         @(negedge iclk);
      end
      checkOutput("rst/no_activity_after", 64'(leak), 64'd0);
   endtask

   initial begin
      int done_rel;
      int zero_cnt;
      n_checks = 0;
      n_fail   = 0;
      irst_n   = 1'b0;
      istart   = 1'b0;
      ic_ready = 1'b0;
      for (int n = 0; n < H*N; n++) begin
         a_mem[n] = '0;
         b_mem[n] = '0;
      end

      vecs[0] = '{"identity", 0, 0, 64'd0, 64'd0, -1, 0, 1'b0, 1'b0, 5, 64'd5, 112, -1};
      vecs[1] = '{"twos_threes", 1, 1, 64'd2, 64'd3, -1, 0, 1'b0, 1'b0, 10, 64'd24, 112, 16};
      vecs[2] = '{"backpressure", 0, 0, 64'd0, 64'd0, 3, 5, 1'b0, 1'b0, 3, 64'd3, 117, -1};
      vecs[3] = '{"istart_ignored", 0, 0, 64'd0, 64'd0, -1, 0, 1'b1, 1'b1, 15, 64'd15, 112, -1};
      vecs[4] = '{"wrap", 2, 1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd2, -1, 0, 1'b0, 1'b0, 2,
                  64'hFFFF_FFFF_FFFF_FFF8, 112, -1};
      vecs[5] = '{"wrap_row1", 2, 1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd2, 6, 2, 1'b0, 1'b0, 6, 64'd8, 114, -1};

      repeat (3) @(negedge iclk);
      checkOutput("reset/obusy", 64'(obusy), 64'd0);
      checkOutput("reset/odone", 64'(odone), 64'd0);
      checkOutput("reset/orden", 64'(orden), 64'd0);
      checkOutput("reset/oc_valid", 64'(oc_valid), 64'd0);
      checkOutput("reset/oc_data", oc_data, 64'd0);
      checkOutput("reset/ocurr_sum", ocurr_sum, 64'd0);
      irst_n = 1'b1;
      @(negedge iclk);

      for (int v = 0; v < 6; v++) begin
         loadMatrices(vecs[v].a_mode, vecs[v].b_mode, vecs[v].a_fill, vecs[v].b_fill);
         for (int n = 0; n < H*N; n++) wait_tab[n] = (n == vecs[v].stall_addr) ? vecs[v].stall_len : 0;
         computeExpected();
         applyStimulus(vecs[v].name, vecs[v].pulse_mid, vecs[v].pulse_done, done_rel, zero_cnt);
         checkOutput({vecs[v].name, "/done_cycle"}, 64'(done_rel), 64'(vecs[v].exp_done));
         checkOutput({vecs[v].name, "/probe"}, c_got[vecs[v].probe_addr], vecs[v].probe_exp);
         if (vecs[v].exp_zero >= 0)
            checkOutput({vecs[v].name, "/zero_sum_cycles"}, 64'(zero_cnt), 64'(vecs[v].exp_zero));
      end

      for (int r = 0; r < 4; r++) begin
         loadMatrices(3, 3, '0, '0);
         for (int n = 0; n < H*N; n++) wait_tab[n] = $urandom_range(0, 3);
         computeExpected();
         applyStimulus($sformatf("random%0d", r), r[0], r[1], done_rel, zero_cnt);
         checkOutput($sformatf("random%0d/done_cycle", r), 64'(done_rel), 64'(done_model));
      end

      resetMidRun();
      loadMatrices(0, 0, '0, '0);
      for (int n = 0; n < H*N; n++) wait_tab[n] = 0;
      computeExpected();
      applyStimulus("after_reset", 1'b0, 1'b0, done_rel, zero_cnt);
      checkOutput("after_reset/done_cycle", 64'(done_rel), 64'd112);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1ms;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] simulation time limit exceeded");
   end

endmodule
